// File: rtl/hdmi_packet_scheduler.sv
// Data-island packet arbiter: picks the packet type for each hdmi slot,
// schedules InfoFrames per frame and lets urgent audio preempt them.
module hdmi_packet_scheduler #(
  parameter int COUNT_WIDTH        = 4,
  parameter int AUDIO_URGENT_LEVEL = 12,
  parameter int INFOFRAME_PERIOD   = 1,
  parameter bit ENABLE_AVI         = 1'b1
) (
  input  logic                   clk_pixel,
  input  logic                   reset,
  input  logic                   frame_start,
  input  logic                   packet_enable,
  input  logic [COUNT_WIDTH-1:0] remaining,
  output logic [7:0]             packet_type,
  output logic                   audio_pop,
  output logic [2:0]             pending,
  output logic [7:0]             missed_count
);

  localparam logic [COUNT_WIDTH-1:0] URGENT =
    COUNT_WIDTH'(AUDIO_URGENT_LEVEL);
  localparam logic [7:0] FC_LAST = 8'(INFOFRAME_PERIOD - 1);

  localparam logic [7:0] PT_NULL   = 8'h00;
  localparam logic [7:0] PT_ACR    = 8'h01;
  localparam logic [7:0] PT_SAMPLE = 8'h02;
  localparam logic [7:0] PT_AVI    = 8'h82;
  localparam logic [7:0] PT_AIF    = 8'h84;

  localparam int ACR = 0;
  localparam int AVI = 1;
  localparam int AIF = 2;

  logic [7:0] fc;
  logic [7:0] fc_next;
  logic [2:0] pend_set;
  logic [2:0] pend_next;
  logic [7:0] type_next;
  logic       pop_next;
  logic [7:0] missed_next;
  logic       urgent;
  logic       has_audio;

  assign urgent    = remaining >= URGENT;
  assign has_audio = remaining != '0;

  always_comb begin
    fc_next     = fc;
    pend_set    = pending;
    missed_next = missed_count;
    if (frame_start) begin
      fc_next       = (fc == FC_LAST) ? 8'd0 : fc + 8'd1;
      pend_set[ACR] = 1'b1;
      if (fc == 8'd0) begin
        pend_set[AIF] = 1'b1;
        if (ENABLE_AVI) pend_set[AVI] = 1'b1;
      end
      if (pending != 3'b000 && missed_count != 8'hff)
        missed_next = missed_count + 8'd1;
    end
  end

  // Slot sees flags after this cycle's frame_start so a new frame's
  // ACR can be consumed by a coincident slot.
  always_comb begin
    pend_next = pend_set;
    type_next = packet_type;
    pop_next  = 1'b0;
    if (packet_enable) begin
      if (urgent) begin
        type_next = PT_SAMPLE;
        pop_next  = 1'b1;
      end else if (pend_set[ACR]) begin
        type_next      = PT_ACR;
        pend_next[ACR] = 1'b0;
      end else if (pend_set[AVI]) begin
        type_next      = PT_AVI;
        pend_next[AVI] = 1'b0;
      end else if (pend_set[AIF]) begin
        type_next      = PT_AIF;
        pend_next[AIF] = 1'b0;
      end else if (has_audio) begin
        type_next = PT_SAMPLE;
        pop_next  = 1'b1;
      end else begin
        type_next = PT_NULL;
      end
    end
  end

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      fc           <= 8'd0;
      pending      <= 3'b000;
      missed_count <= 8'd0;
      packet_type  <= PT_NULL;
      audio_pop    <= 1'b0;
    end else begin
      fc           <= fc_next;
      pending      <= pend_next;
      missed_count <= missed_next;
      packet_type  <= type_next;
      audio_pop    <= pop_next;
    end
  end

endmodule

// File: tb/tb_hdmi_packet_scheduler.sv
// Bench for hdmi_packet_scheduler: vector table through a scoreboard
// queue plus hand-written InfoFrame period and saturation sequences.
module tb_hdmi_packet_scheduler;

  typedef struct {
    logic       fs;
    logic       pe;
    logic [3:0] rem;
    logic [7:0] ty;
    logic       pop;
    logic [2:0] pend;
    logic [7:0] miss;
  } vec_t;

  typedef struct {
    logic [7:0] ty;
    logic       pop;
    logic [2:0] pend;
    logic [7:0] miss;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic fs0, pe0;
  logic [3:0] rem0;
  logic [7:0] ty0;
  logic pop0;
  logic [2:0] pend0;
  logic [7:0] miss0;
  logic fs1, pe1;
  logic [3:0] rem1;
  logic [7:0] ty1;
  logic pop1;
  logic [2:0] pend1;
  logic [7:0] miss1;

  int n_checks = 0;
  int n_fail   = 0;
  exp_t sbq[$];
  vec_t vecs[17];

  always #5 clk = ~clk;

  hdmi_packet_scheduler dut0 (
    .clk_pixel     (clk),
    .reset         (rst),
    .frame_start   (fs0),
    .packet_enable (pe0),
    .remaining     (rem0),
    .packet_type   (ty0),
    .audio_pop     (pop0),
    .pending       (pend0),
    .missed_count  (miss0)
  );

  hdmi_packet_scheduler #(.INFOFRAME_PERIOD(3)) dut1 (
    .clk_pixel     (clk),
    .reset         (rst),
    .frame_start   (fs1),
    .packet_enable (pe1),
    .remaining     (rem1),
    .packet_type   (ty1),
    .audio_pop     (pop1),
    .pending       (pend1),
    .missed_count  (miss1)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // test 2: full schedule with audio filling the tail
    vecs[0]  = '{1'b1, 1'b0, 4'd3,  8'h00, 1'b0, 3'd7, 8'd0};
    vecs[1]  = '{1'b0, 1'b1, 4'd3,  8'h01, 1'b0, 3'd6, 8'd0};
    vecs[2]  = '{1'b0, 1'b1, 4'd3,  8'h82, 1'b0, 3'd4, 8'd0};
    vecs[3]  = '{1'b0, 1'b1, 4'd3,  8'h84, 1'b0, 3'd0, 8'd0};
    vecs[4]  = '{1'b0, 1'b1, 4'd3,  8'h02, 1'b1, 3'd0, 8'd0};
    vecs[5]  = '{1'b0, 1'b1, 4'd3,  8'h02, 1'b1, 3'd0, 8'd0};
    vecs[6]  = '{1'b0, 1'b0, 4'd3,  8'h02, 1'b0, 3'd0, 8'd0};
    // test 3: urgent audio preempts ACR, 11 does not
    vecs[7]  = '{1'b1, 1'b0, 4'd12, 8'h02, 1'b0, 3'd7, 8'd0};
    vecs[8]  = '{1'b0, 1'b1, 4'd12, 8'h02, 1'b1, 3'd7, 8'd0};
    vecs[9]  = '{1'b0, 1'b1, 4'd11, 8'h01, 1'b0, 3'd6, 8'd0};
    vecs[10] = '{1'b0, 1'b1, 4'd0,  8'h82, 1'b0, 3'd4, 8'd0};
    vecs[11] = '{1'b0, 1'b1, 4'd0,  8'h84, 1'b0, 3'd0, 8'd0};
    vecs[12] = '{1'b0, 1'b1, 4'd0,  8'h00, 1'b0, 3'd0, 8'd0};
    // test 6: coincident frame_start and slot
    vecs[13] = '{1'b1, 1'b1, 4'd0,  8'h01, 1'b0, 3'd6, 8'd0};
    vecs[14] = '{1'b1, 1'b0, 4'd0,  8'h01, 1'b0, 3'd7, 8'd1};
    vecs[15] = '{1'b0, 1'b1, 4'd15, 8'h02, 1'b1, 3'd7, 8'd1};
    vecs[16] = '{1'b0, 1'b1, 4'd1,  8'h01, 1'b0, 3'd6, 8'd1};

    rst = 1'b1;
    fs0 = 1'b1; pe0 = 1'b1; rem0 = 4'd5;
    fs1 = 1'b1; pe1 = 1'b1; rem1 = 4'd5;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("rst%0d.type", c), 32'(ty0), 32'h00);
      chk($sformatf("rst%0d.pop", c), 32'(pop0), 32'h0);
      chk($sformatf("rst%0d.pend", c), 32'(pend0), 32'h0);
      chk($sformatf("rst%0d.miss", c), 32'(miss0), 32'h0);
      chk($sformatf("rst%0d.type1", c), 32'(ty1), 32'h00);
    end
    rst = 1'b0;
    fs0 = 1'b0; pe0 = 1'b0; rem0 = 4'd0;
    fs1 = 1'b0; pe1 = 1'b0; rem1 = 4'd0;
    tick();

    foreach (vecs[i]) begin
      fs0  = vecs[i].fs;
      pe0  = vecs[i].pe;
      rem0 = vecs[i].rem;
      sbq.push_back('{vecs[i].ty, vecs[i].pop, vecs[i].pend, vecs[i].miss});
      tick();
      if (sbq.size() != 0) begin
        exp_t e;
        e = sbq.pop_front();
        chk($sformatf("vec%0d.type", i), 32'(ty0), 32'(e.ty));
        chk($sformatf("vec%0d.pop", i), 32'(pop0), 32'(e.pop));
        chk($sformatf("vec%0d.pend", i), 32'(pend0), 32'(e.pend));
        chk($sformatf("vec%0d.miss", i), 32'(miss0), 32'(e.miss));
      end
    end
    fs0 = 1'b0; pe0 = 1'b0; rem0 = 4'd0;
    chk("sb_empty", 32'(sbq.size()), 32'd0);

    // test 4: InfoFrames only every third frame
    for (int f = 0; f < 4; f++) begin
      fs1 = 1'b1; pe1 = 1'b0; rem1 = 4'd0;
      tick();
      fs1 = 1'b0;
      for (int s = 0; s < 3; s++) begin
        logic [7:0] et;
        pe1 = 1'b1;
        if (s == 0) et = 8'h01;
        else if (f % 3 == 0) et = (s == 1) ? 8'h82 : 8'h84;
        else et = 8'h00;
        tick();
        chk($sformatf("per f%0d s%0d", f, s), 32'(ty1), 32'(et));
        chk($sformatf("per f%0d s%0d pop", f, s), 32'(pop1), 32'h0);
      end
      pe1 = 1'b0;
    end
    chk("per.miss", 32'(miss1), 32'd0);

    // test 5: missed frames saturate
    rst = 1'b1;
    tick();
    rst = 1'b0;
    fs0 = 1'b1;
    tick();
    chk("miss.first", 32'(miss0), 32'd0);
    tick();
    chk("miss.second", 32'(miss0), 32'd1);
    for (int k = 3; k <= 302; k++) begin
      tick();
      if (k == 255) chk("miss.254", 32'(miss0), 32'd254);
      if (k == 256) chk("miss.255", 32'(miss0), 32'd255);
    end
    fs0 = 1'b0;
    tick();
    chk("miss.sat", 32'(miss0), 32'd255);
    chk("miss.pend", 32'(pend0), 32'd7);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hdmi_packet_scheduler.md
Name: hdmi_packet_scheduler

Overview:
Per-slot data-island packet arbiter for the hdmi core, clocked by clk_pixel. On each packet_enable slot it selects which packet_type the hdmi core emits: Audio Clock Regeneration, AVI InfoFrame, Audio InfoFrame, Audio Sample or Null. It also pops the audio sample buffer when a sample packet is chosen. It replaces ad-hoc packet sequencing in top-level designs and adds periodic InfoFrame scheduling, audio-urgency preemption and missed-schedule accounting.

Parameters:
COUNT_WIDTH, 4, width of the audio buffer occupancy input `remaining`
AUDIO_URGENT_LEVEL, 12, occupancy at or above which audio samples preempt all other packets
INFOFRAME_PERIOD, 1, InfoFrames (AVI and Audio) are scheduled every INFOFRAME_PERIOD frames; legal range 1..255
ENABLE_AVI, 1, 0 means the AVI InfoFrame is never scheduled

Ports:
clk_pixel  input  1  pixel clock; the only clock
reset  input  1  synchronous, active-high reset
frame_start  input  1  one-cycle pulse at frame origin (cx==0 && cy==0)
packet_enable  input  1  one-cycle pulse from the hdmi core marking a packet slot
remaining  input  COUNT_WIDTH  audio buffer occupancy in samples
packet_type  output  8  packet type for the hdmi core; held between slots
audio_pop  output  1  one-cycle pulse; buffer advances and the sample is latched
pending  output  3  {aif, avi, acr} pending flags
missed_count  output  8  saturating count of frames that started with work still pending

Behaviour:
- Reset: packet_type=8'h00, audio_pop=0, pending=3'b000, missed_count=0, frame counter=0. Reset overrides every other input in that cycle.
- Frame counter fc: 0..INFOFRAME_PERIOD-1.
  - On frame_start, fc wraps to 0 at INFOFRAME_PERIOD-1, otherwise increments.
  - Flag setting uses the pre-increment fc value.
- On frame_start:
  - Set acr unconditionally.
  - If fc==0, set aif, and set avi when ENABLE_AVI=1.
  - If pending!=0 before setting, increment missed_count, saturating at 255.
- Slot arbitration: registered and evaluated on the edge where packet_enable=1.
  - Pending flags used are those after any same-cycle frame_start set, so frame_start is applied first.
  - Priority, highest first:
    1. remaining >= AUDIO_URGENT_LEVEL: packet_type=8'h02, audio_pop=1.
    2. acr pending: packet_type=8'h01, clear acr.
    3. avi pending: packet_type=8'h82, clear avi.
    4. aif pending: packet_type=8'h84, clear aif.
    5. remaining > 0: packet_type=8'h02, audio_pop=1.
    6. Otherwise: packet_type=8'h00.
  - If a flag is cleared by a slot in the same cycle frame_start sets it, the slot consumes the flag and it ends clear. The missed check uses pre-frame_start state.
- Latency: packet_type and audio_pop are valid on the cycle after the packet_enable edge. The hdmi core samples packet_type at the next slot boundary.
- audio_pop:
  - High for exactly one cycle per sample slot.
  - Never asserted when remaining==0.
  - Never asserted without packet_enable.
- packet_type is held constant when packet_enable=0.
- Back-to-back packet_enable on consecutive cycles is legal; each pulse is a separate slot.
- Arithmetic: all comparisons on remaining are unsigned. AUDIO_URGENT_LEVEL is compared after zero-extension to COUNT_WIDTH.
- No state machine beyond the flags and fc. The design is fully synchronous with no combinational path from inputs to outputs.

Test Plan:
1. Reset held 3 cycles with packet_enable=1 and remaining=5 -> packet_type=0x00, audio_pop=0, pending=0, missed_count=0 throughout.
2. frame_start, then 5 slots with remaining=3 (defaults) -> packet_types 0x01, 0x82, 0x84, 0x02, 0x02; audio_pop only on slots 4 and 5; pending goes 7, 6, 4, 0.
3. frame_start, then remaining=12 at the first slot -> 0x02 with audio_pop; acr still pending; next slot with remaining=11 -> 0x01.
4. INFOFRAME_PERIOD=3, four frame_starts each followed by 3 slots with remaining=0 -> frame 0: 0x01, 0x82, 0x84; frames 1 and 2: 0x01, 0x00, 0x00; frame 3: 0x01, 0x82, 0x84.
5. Two frame_starts with no slots between them, then 300 more frame_starts -> missed_count 1 after the second pulse; saturates at 255.
6. frame_start and packet_enable in the same cycle from pending=0 with remaining=0 -> packet_type=0x01, pending=3'b110, missed_count unchanged.
